// File: rtl/alu_result_stage.sv
// alu_result_stage: registers adder results with Z/N/C/V flags and optional signed saturation.
// Results pass through a 2-entry valid/ready FIFO. The stage also keeps a sticky overflow bit and a saturating overflow count.
module alu_result_stage #(
    parameter int WIDTH  = 16,
    parameter bit SAT_EN = 1'b0,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_m,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic             sticky_v,
    input  logic             clr_sticky,
    output logic [CNT_W-1:0] ovf_count
);
    localparam int EW = WIDTH + 4;

    logic [EW-1:0]    mem [2];
    logic [1:0]       count;
    logic             wr_ptr, rd_ptr;
    logic [WIDTH-1:0] bx, res;
    logic             sa, sb, ss, v, push, pop;
    logic [EW-1:0]    entry;

    always_comb begin
        bx    = in_m ? ~in_b : in_b;
        sa    = in_a[WIDTH-1];
        sb    = bx[WIDTH-1];
        ss    = in_sum[WIDTH-1];
        v     = (sa == sb) && (ss != sa);
        res   = (SAT_EN && v) ? (sa ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) : in_sum;
        entry = {res, v, in_cout, res[WIDTH-1], res == '0};
    end

    // Handshake decodes only registered state, so there is no in_* to out_* path
    assign in_ready   = count != 2'd2;
    assign out_valid  = count != 2'd0;
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign out_result = mem[rd_ptr][EW-1:4];
    assign out_flags  = mem[rd_ptr][3:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            mem[0]    <= '0;
            mem[1]    <= '0;
            sticky_v  <= 1'b0;
            ovf_count <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            if (push != pop) count <= push ? count + 2'd1 : count - 2'd1;
            if (clr_sticky) begin
                sticky_v  <= 1'b0;
                ovf_count <= '0;
            end
            // A same-edge clear is applied first, so the overflow counts from zero
            if (push && v) begin
                sticky_v  <= 1'b1;
                ovf_count <= clr_sticky ? CNT_W'(1) : (&ovf_count ? ovf_count : ovf_count + CNT_W'(1));
            end
        end
    end
endmodule
